// File: rtl/tile_ram_to_fifo.sv
// Strided TR x TC tile loader: walks a row-major feature map, reads a fixed-latency RAM, pushes raster-ordered words to a FIFO.
// Optional LOAD_CHKSUM_EN adds an XOR checksum over every pushed word of the tile.
module tile_ram_to_fifo #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int TR     = 64,
    parameter int TC     = 16,
    parameter int LINE   = 16,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] ram_addr,
    input  logic [DW-1:0] data_from_ram,
    output logic          fifo_push,
    output logic [DW-1:0] data_to_fifo,
    input  logic          fifo_almost_full
`ifdef LOAD_CHKSUM_EN
    ,
    output logic [DW-1:0] chksum
`endif
);

    localparam int RW = (TR > 1) ? $clog2(TR) : 1;
    localparam int CW = (TC > 1) ? $clog2(TC) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t            state, state_nxt;
    logic [RW-1:0]     row;
    logic [CW-1:0]     col;
    logic [AW-1:0]     row_base;
    logic [RD_LAT-1:0] vld_pipe;
    logic              issue, start_ok, last_col, last_elem;

    assign last_col  = (col == CW'(TC - 1));
    assign last_elem = last_col && (row == RW'(TR - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ISSUE;
            ISSUE:   if (issue && last_elem) state_nxt = DRAIN;
            // The push register is part of the pipeline: wait for the last push to leave it.
            DRAIN:   if (vld_pipe == '0 && !fifo_push) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == ISSUE) || (state == DRAIN);
        done     = (state == DONE);
        issue    = (state == ISSUE) && !fifo_almost_full;
        start_ok = (state == IDLE) && start;
    end

    // ram_addr is preloaded with base on start, so element (0,0) is on the bus in the first ISSUE cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row          <= '0;
            col          <= '0;
            row_base     <= '0;
            ram_addr     <= '0;
            vld_pipe     <= '0;
            fifo_push    <= 1'b0;
            data_to_fifo <= '0;
        end else begin
            vld_pipe  <= (vld_pipe << 1) | RD_LAT'(issue);
            fifo_push <= vld_pipe[RD_LAT-1];
            if (vld_pipe[RD_LAT-1]) data_to_fifo <= data_from_ram;
            if (start_ok) begin
                row      <= '0;
                col      <= '0;
                row_base <= base_addr;
                ram_addr <= base_addr;
            end else if (issue) begin
                if (last_col) begin
                    col      <= '0;
                    row      <= last_elem ? '0 : row + RW'(1);
                    row_base <= row_base + AW'(LINE);
                    ram_addr <= row_base + AW'(LINE);
                end else begin
                    col      <= col + CW'(1);
                    ram_addr <= ram_addr + AW'(1);
                end
            end
        end
    end

`ifdef LOAD_CHKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           chksum <= '0;
        else if (start_ok)  chksum <= '0;
        else if (fifo_push) chksum <= chksum ^ data_to_fifo;
    end
`endif

endmodule

// File: tb/tb_tile_ram_to_fifo.sv
// Randomized bench for tile_ram_to_fifo: two instances (4x3 tile, 1x4 tile) against an address-arithmetic reference.
// RAM word at address a is a ^ salt; expected push k is f(base + (k/TC)*LINE + k%TC).
module tb_tile_ram_to_fifo;

    localparam int RD_LAT = 2;
    localparam int TRA = 4, TCA = 3, LA = 8;
    localparam int TRB = 1, TCB = 4, LB = 5;
    localparam int NA = TRA * TCA, NB = TRB * TCB;

    logic        clk = 1'b0;
    logic        rst, start, af;
    logic [31:0] base, salt;

    logic        busy_a, done_a, push_a, busy_b, done_b, push_b;
    logic [31:0] addr_a, dtf_a, addr_b, dtf_b;
    logic [31:0] ra1, ra2, rb1, rb2;
`ifdef LOAD_CHKSUM_EN
    logic [31:0] ck_a, ck_b;
`endif

    always #5 clk = ~clk;

    tile_ram_to_fifo #(.AW(32), .DW(32), .TR(TRA), .TC(TCA), .LINE(LA), .RD_LAT(RD_LAT)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .base_addr(base), .busy(busy_a), .done(done_a),
        .ram_addr(addr_a), .data_from_ram(ra2), .fifo_push(push_a), .data_to_fifo(dtf_a),
        .fifo_almost_full(af)
`ifdef LOAD_CHKSUM_EN
        , .chksum(ck_a)
`endif
    );

    tile_ram_to_fifo #(.AW(32), .DW(32), .TR(TRB), .TC(TCB), .LINE(LB), .RD_LAT(RD_LAT)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .base_addr(base), .busy(busy_b), .done(done_b),
        .ram_addr(addr_b), .data_from_ram(rb2), .fifo_push(push_b), .data_to_fifo(dtf_b),
        .fifo_almost_full(af)
`ifdef LOAD_CHKSUM_EN
        , .chksum(ck_b)
`endif
    );

    // Fixed-latency RAM model: data for an address appears RD_LAT cycles after it is driven.
    always @(posedge clk) begin
        ra1 <= addr_a ^ salt;
        ra2 <= ra1;
        rb1 <= addr_b ^ salt;
        rb2 <= rb1;
    end

    int n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [31:0] b, input int k, input int tc,
                                             input int line, input logic [31:0] s);
        logic [31:0] a;
        a = b + 32'(k / tc) * 32'(line) + 32'(k % tc);
        return a ^ s;
    endfunction

    // Monitor sampled on the falling edge; nidx numbers falling edges.
    int          nidx = 0, da = 0, db = 0, done_a_n = 0, done_b_n = 0, first_a = 0, first_b = 0;
    logic [31:0] pa_q[$], pb_q[$];
    logic        af_prev, rst_prev, start_prev;
    logic [31:0] addr_prev;

    always @(negedge clk) begin
        nidx <= nidx + 1;
        if (push_a) begin
            if (pa_q.size() == 0) first_a <= nidx;
            pa_q.push_back(dtf_a);
        end
        if (push_b) begin
            if (pb_q.size() == 0) first_b <= nidx;
            pb_q.push_back(dtf_b);
        end
        if (done_a) begin da <= da + 1; done_a_n <= nidx; end
        if (done_b) begin db <= db + 1; done_b_n <= nidx; end
        if (af_prev === 1'b1 && rst && rst_prev === 1'b1 && start_prev === 1'b0)
            chk("addr_hold_af", addr_a, addr_prev);
        af_prev    <= af;
        rst_prev   <= rst;
        start_prev <= start;
        addr_prev  <= addr_a;
    end

    int start_n;

    task automatic start_tile(input logic [31:0] b);
        @(posedge clk); #1;
        base    = b;
        start   = 1'b1;
        start_n = nidx;
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    // mode: 0 = af low, 1 = random af, 2 = af toggling every cycle
    task automatic wait_done(input int budget, input int mode);
        int n = 0;
        while (da == 0 && n < budget) begin
            @(posedge clk); #1;
            if (mode == 1)      af = ($urandom_range(0, 3) == 0);
            else if (mode == 2) af = ~af;
            n++;
        end
        af = 1'b0;
        chk("done_within_budget", 32'(n < budget), 32'd1);
        repeat (4) begin @(posedge clk); #1; end
    endtask

    task automatic clear_mon();
        pa_q.delete(); pb_q.delete();
        da = 0; db = 0;
    endtask

    task automatic check_tile(input logic [31:0] b, input bit timed);
        logic [31:0] xa, xb;
        xa = '0; xb = '0;
        chk("a_npush", pa_q.size(), NA);
        chk("b_npush", pb_q.size(), NB);
        for (int k = 0; k < NA; k++) begin
            xa ^= exp_word(b, k, TCA, LA, salt);
            if (k < pa_q.size()) chk("a_word", pa_q[k], exp_word(b, k, TCA, LA, salt));
        end
        for (int k = 0; k < NB; k++) begin
            xb ^= exp_word(b, k, TCB, LB, salt);
            if (k < pb_q.size()) chk("b_word", pb_q[k], exp_word(b, k, TCB, LB, salt));
        end
        chk("a_ndone", da, 1);
        chk("b_ndone", db, 1);
        chk("a_busy_end", busy_a, 0);
        chk("b_busy_end", busy_b, 0);
`ifdef LOAD_CHKSUM_EN
        chk("a_chksum", ck_a, xa);
        chk("b_chksum", ck_b, xb);
`endif
        if (timed) begin
            chk("a_first_push_t", first_a - start_n, RD_LAT + 2);
            chk("a_done_t", done_a_n - start_n, NA + RD_LAT + 3);
            chk("b_first_push_t", first_b - start_n, RD_LAT + 2);
            chk("b_done_t", done_b_n - start_n, NB + RD_LAT + 3);
        end
        clear_mon();
    endtask

    task automatic chk_quiet_a(input string tag);
        chk({tag, "_busy"}, busy_a, 0);
        chk({tag, "_done"}, done_a, 0);
        chk({tag, "_push"}, push_a, 0);
        chk({tag, "_addr"}, addr_a, 0);
        chk({tag, "_data"}, dtf_a, 0);
    endtask

    initial begin
        logic [31:0] b;
        int          na0, nb0;
        rst = 1'b0; start = 1'b0; af = 1'b0; base = '0; salt = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_quiet_a("reset");
        chk("reset_b_addr", addr_b, 0);
`ifdef LOAD_CHKSUM_EN
        chk("reset_chksum", ck_a, 0);
`endif
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        clear_mon();

        // plain tile, identity memory
        chk("busy_idle", busy_a, 0);
        start_tile(32'h10);
        chk("busy_after_start", busy_a, 1);
        wait_done(200, 0);
        check_tile(32'h10, 1'b1);

        // almost_full window in the middle of the tile
        start_tile(32'h10);
        repeat (3) begin @(posedge clk); #1; end
        af = 1'b1;
        repeat (7) begin @(posedge clk); #1; end
        af = 1'b0;
        wait_done(200, 0);
        check_tile(32'h10, 1'b0);

        // second start while busy must be ignored
        start_tile(32'h10);
        repeat (4) begin @(posedge clk); #1; end
        base = 32'h100; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(200, 0);
        check_tile(32'h10, 1'b1);

        // reset mid-tile
        start_tile(32'h40);
        repeat (6) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(negedge clk);
        chk_quiet_a("midrst");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        na0 = pa_q.size(); nb0 = pb_q.size();
        repeat (12) begin @(posedge clk); #1; end
        chk("midrst_no_push_a", pa_q.size(), na0);
        chk("midrst_no_push_b", pb_q.size(), nb0);
        chk("midrst_no_done_a", da, 0);
        chk("midrst_no_done_b", db, 0);
        clear_mon();
        start_tile(32'h40);
        wait_done(200, 0);
        check_tile(32'h40, 1'b1);

        // address wrap at the top of the space
        start_tile(32'hFFFF_FFFE);
        wait_done(200, 0);
        check_tile(32'hFFFF_FFFE, 1'b1);

        // randomized bases, data salt and backpressure
        for (int i = 0; i < 8; i++) begin
            salt = $urandom;
            b = (i % 2 == 1) ? $urandom : 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            start_tile(b);
            wait_done(400, (i == 0) ? 2 : 1);
            check_tile(b, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
